issue_scoreboard: RTL and testbench

//  Issue controller between decode and execute. Tracks destination registers with writes in flight
//  in a 32-entry busy scoreboard and stalls decode on RAW/WAW hazards or when in-flight writes reach

---
 rtl/issue_scoreboard_if.sv | 31 +++
 rtl/issue_scoreboard.sv | 169 ++++++++++++++++
 tb/tb_issue_scoreboard.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue and issue-to-execute handshake bundle for issue_scoreboard.
// The master modport is the decode/execute side; slave is the controller.
interface issue_scoreboard_if;
    logic       id_valid;
    logic       id_ready;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rt_used;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic [3:0] id_alu_control;
    logic       ex_valid;
    logic       ex_ready;
    logic [3:0] ex_alu_control;
    logic [4:0] ex_dest;
    logic       ex_reg_write;

    modport master (
        output id_valid, id_rs, id_rt, id_rt_used, id_dest, id_reg_write, id_alu_control,
        input  id_ready,
        input  ex_valid, ex_alu_control, ex_dest, ex_reg_write,
        output ex_ready
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rt_used, id_dest, id_reg_write, id_alu_control,
        output id_ready,
        output ex_valid, ex_alu_control, ex_dest, ex_reg_write,
        input  ex_ready
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue controller: busy-register scoreboard, hazard stall, one-entry issue register, flush.
// Optional macro ISSUE_WB_BYPASS_EN lets a same-cycle writeback clear hazards before issue.
module issue_scoreboard #(
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    issue_scoreboard_if.slave    io,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_dest,
    input  logic                 flush,
    output logic [31:0]          busy_mask,
    output logic [CNT_W-1:0]     stall_cycles
);
    localparam int INF_W = 5;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [31:0]       busy_r;
    logic [INF_W-1:0]  inflight_r;
    logic [CNT_W-1:0]  stall_cycles_r;
    logic              ex_valid_r;
    logic [3:0]        ex_alu_control_r;
    logic [4:0]        ex_dest_r;
    logic              ex_reg_write_r;

    logic [31:0]       wb_clear_mask_s;
    logic [31:0]       set_mask_s;
    logic [31:0]       hazard_busy_s;
    logic [INF_W-1:0]  hazard_inflight_s;
    logic              hazard_s;
    logic              id_ready_s;
    logic              fire_s;
    logic              dest_writes_s;

    // Writeback clear mask; writebacks during a flush or in FLUSH are dropped.
    always_comb begin
        wb_clear_mask_s = 32'd0;
        if (wb_valid && (wb_dest != 5'd0) && busy_r[wb_dest] && !flush && (state_r != ST_FLUSH)) begin
            wb_clear_mask_s = 32'd1 << wb_dest;
        end else begin
            wb_clear_mask_s = 32'd0;
        end
    end

`ifdef ISSUE_WB_BYPASS_EN
    assign hazard_busy_s     = busy_r & ~wb_clear_mask_s;
    assign hazard_inflight_s = inflight_r - {{(INF_W-1){1'b0}}, |wb_clear_mask_s};
`else
    assign hazard_busy_s     = busy_r;
    assign hazard_inflight_s = inflight_r;
`endif

    assign dest_writes_s = io.id_reg_write && (io.id_dest != 5'd0);

    // RAW/WAW hazards plus in-flight capacity; register 0 is never a hazard.
    always_comb begin
        hazard_s = 1'b0;
        if ((io.id_rs != 5'd0) && hazard_busy_s[io.id_rs]) begin
            hazard_s = 1'b1;
        end else if (io.id_rt_used && (io.id_rt != 5'd0) && hazard_busy_s[io.id_rt]) begin
            hazard_s = 1'b1;
        end else if (dest_writes_s && hazard_busy_s[io.id_dest]) begin
            hazard_s = 1'b1;
        end else if (dest_writes_s && (hazard_inflight_s == INF_W'(MAX_INFLIGHT))) begin
            hazard_s = 1'b1;
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign id_ready_s = !rst && ((state_r == ST_RUN) || (state_r == ST_STALL)) && !flush
                        && !hazard_s && (!ex_valid_r || io.ex_ready);
    assign fire_s     = io.id_valid && id_ready_s;
    assign set_mask_s = (fire_s && dest_writes_s) ? (32'd1 << io.id_dest) : 32'd0;

    // Next-state logic for the RUN/STALL/FLUSH controller.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (flush) begin
                    state_next_s = ST_FLUSH;
                end else if (io.id_valid && !id_ready_s) begin
                    state_next_s = ST_STALL;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STALL: begin
                if (flush) begin
                    state_next_s = ST_FLUSH;
                end else if (fire_s || !io.id_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_STALL;
                end
            end
            ST_FLUSH: state_next_s = ST_RUN;
            default:  state_next_s = ST_RUN;
        endcase
    end

    // State register and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_RUN;
            stall_cycles_r <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            if ((state_r == ST_STALL) && (stall_cycles_r != {CNT_W{1'b1}})) begin
                stall_cycles_r <= stall_cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
        end
    end

    // Scoreboard: a set wins over a clear of the same bit; a set plus a clear leaves inflight unchanged.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            busy_r     <= 32'd0;
            inflight_r <= {INF_W{1'b0}};
        end else begin
            busy_r <= (busy_r & ~wb_clear_mask_s) | set_mask_s;
            case ({|set_mask_s, |wb_clear_mask_s})
                2'b10:   inflight_r <= inflight_r + {{(INF_W-1){1'b0}}, 1'b1};
                2'b01:   inflight_r <= inflight_r - {{(INF_W-1){1'b0}}, 1'b1};
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    // Issue register toward execute; contents hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_r       <= 1'b0;
            ex_alu_control_r <= 4'd0;
            ex_dest_r        <= 5'd0;
            ex_reg_write_r   <= 1'b0;
        end else if (flush) begin
            ex_valid_r <= 1'b0;
        end else if (fire_s) begin
            ex_valid_r       <= 1'b1;
            ex_alu_control_r <= io.id_alu_control;
            ex_dest_r        <= io.id_dest;
            ex_reg_write_r   <= io.id_reg_write;
        end else if (ex_valid_r && io.ex_ready) begin
            ex_valid_r <= 1'b0;
        end else begin
            ex_valid_r <= ex_valid_r;
        end
    end

    assign io.id_ready       = id_ready_s;
    assign io.ex_valid       = ex_valid_r;
    assign io.ex_alu_control = ex_alu_control_r;
    assign io.ex_dest        = ex_dest_r;
    assign io.ex_reg_write   = ex_reg_write_r;
    assign busy_mask         = busy_r;
    assign stall_cycles      = stall_cycles_r;
endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: issued instructions are queued as expected execute
// transactions and a separate monitor checks each execute handshake against the queue.
module tb_issue_scoreboard;
    logic        clk;
    logic        rst;
    logic        wb_valid;
    logic [4:0]  wb_dest;
    logic        flush;
    logic [31:0] busy_mask;
    logic [15:0] stall_cycles;

    issue_scoreboard_if bus();

    issue_scoreboard #(.MAX_INFLIGHT(4), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .io           (bus),
        .wb_valid     (wb_valid),
        .wb_dest      (wb_dest),
        .flush        (flush),
        .busy_mask    (busy_mask),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        logic [3:0] alu;
        logic [4:0] dest;
        logic       rw;
    } ex_txn_t;

    ex_txn_t exp_q[$];
    int tests = 0;
    int fails = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [3:0] alu, input logic [4:0] rs, input logic [4:0] rt,
                          input logic rt_used, input logic [4:0] dest, input logic rw);
        bus.id_valid       = 1'b1;
        bus.id_alu_control = alu;
        bus.id_rs          = rs;
        bus.id_rt          = rt;
        bus.id_rt_used     = rt_used;
        bus.id_dest        = dest;
        bus.id_reg_write   = rw;
    endtask

    // Checks id_ready after inputs settle; on an expected fire, queue the execute transaction.
    task automatic expect_ready(input string name, input logic exp);
        #1;
        check(name, {31'd0, bus.id_ready}, {31'd0, exp});
        if (bus.id_valid && bus.id_ready) begin
            exp_q.push_back({bus.id_alu_control, bus.id_dest, bus.id_reg_write});
        end
    endtask

    task automatic retire(input logic [4:0] dest);
        wb_valid = 1'b1;
        wb_dest  = dest;
        step();
        wb_valid = 1'b0;
    endtask

    // Monitor: every execute handshake must match the oldest queued issue.
    always @(negedge clk) begin
        if (!rst && bus.ex_valid && bus.ex_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ex_unexpected: got alu=0x%0h dest=%0d expected no transaction",
                         bus.ex_alu_control, bus.ex_dest);
            end else begin
                ex_txn_t e;
                e = exp_q.pop_front();
                check("ex_alu", {28'd0, bus.ex_alu_control}, {28'd0, e.alu});
                check("ex_dest", {27'd0, bus.ex_dest}, {27'd0, e.dest});
                check("ex_rw", {31'd0, bus.ex_reg_write}, {31'd0, e.rw});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; wb_valid = 1'b0; wb_dest = 5'd0;
        bus.id_valid = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_rt_used = 1'b0;
        bus.id_dest = 5'd0; bus.id_reg_write = 1'b0; bus.id_alu_control = 4'd0;
        bus.ex_ready = 1'b1;

        // Reset
        step();
        check("rst_id_ready", {31'd0, bus.id_ready}, 32'd0);
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_ex_fields", {22'd0, bus.ex_alu_control, bus.ex_dest, bus.ex_reg_write}, 32'd0);
        check("rst_busy", busy_mask, 32'd0);
        check("rst_stall", {16'd0, stall_cycles}, 32'd0);
        step();
        rst = 1'b0;
        expect_ready("post_rst_ready", 1'b1);

        // Basic issue of r3
        set_id(4'h2, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1);
        expect_ready("t2_ready", 1'b1);
        step();
        bus.id_valid = 1'b0;
        check("t2_ex_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("t2_ex_dest", {27'd0, bus.ex_dest}, 32'd3);
        check("t2_busy", busy_mask, 32'h8);
        step();
        check("t2_ex_drain", {31'd0, bus.ex_valid}, 32'd0);

        // RAW on r3, resolved by writeback
        set_id(4'h5, 5'd3, 5'd0, 1'b0, 5'd6, 1'b1);
        expect_ready("t3_raw_ready", 1'b0);
        step();
        step();
        step();
        check("t3_stall_cnt", {16'd0, stall_cycles}, 32'd2);
        wb_valid = 1'b1;
        wb_dest  = 5'd3;
        expect_ready("t3_wb_cycle_ready", 1'b0);
        step();
        wb_valid = 1'b0;
        expect_ready("t3_after_wb_ready", 1'b1);
        step();
        bus.id_valid = 1'b0;
        check("t3_busy", busy_mask, 32'h40);
        check("t3_ex_dest", {27'd0, bus.ex_dest}, 32'd6);
        check("t3_stall_final", {16'd0, stall_cycles}, 32'd4);
        step();
        check("t3_stall_hold", {16'd0, stall_cycles}, 32'd4);
        retire(5'd6);
        check("t3_clear", busy_mask, 32'd0);

        // Capacity: four writes in flight, fifth stalls
        for (int i = 1; i <= 4; i++) begin
            set_id(4'(i), 5'd0, 5'd0, 1'b0, 5'(i), 1'b1);
            expect_ready("t4_fill_ready", 1'b1);
            step();
        end
        check("t4_busy_full", busy_mask, 32'h1E);
        set_id(4'h7, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1);
        expect_ready("t4_cap_ready", 1'b0);
        step();
        step();
        expect_ready("t4_cap_hold", 1'b0);
        wb_valid = 1'b1;
        wb_dest  = 5'd2;
        step();
        wb_valid = 1'b0;
        expect_ready("t4_after_wb_ready", 1'b1);
        step();
        check("t4_busy_after", busy_mask, 32'h3A);
        check("t4_stall_cnt", {16'd0, stall_cycles}, 32'd7);
        set_id(4'h8, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1);
        expect_ready("t4_still_full", 1'b0);
        bus.id_valid = 1'b0;
        retire(5'd1);
        retire(5'd5);
        check("t4_busy_18", busy_mask, 32'h18);

        // Backpressure
        bus.ex_ready = 1'b0;
        set_id(4'h9, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ready("t5_first_ready", 1'b1);
        step();
        set_id(4'hA, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            expect_ready("t5_bp_ready", 1'b0);
            check("t5_bp_alu", {28'd0, bus.ex_alu_control}, 32'h9);
            check("t5_bp_valid", {31'd0, bus.ex_valid}, 32'd1);
            step();
        end
        bus.ex_ready = 1'b1;
        expect_ready("t5_release_ready", 1'b1);
        step();
        bus.id_valid = 1'b0;
        check("t5_new_valid", {31'd0, bus.ex_valid}, 32'd1);
        check("t5_new_alu", {28'd0, bus.ex_alu_control}, 32'hA);
        step();

        // Flush with busy r3/r4 and a held instruction
        bus.ex_ready = 1'b0;
        set_id(4'hB, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_ready("t6_load_ready", 1'b1);
        step();
        check("t6_pre_busy", busy_mask, 32'h18);
        check("t6_pre_valid", {31'd0, bus.ex_valid}, 32'd1);
        flush = 1'b1;
        set_id(4'hC, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1);
        expect_ready("t6_flush_ready", 1'b0);
        exp_q.delete();
        step();
        flush = 1'b0;
        bus.ex_ready = 1'b1;
        check("t6_busy", busy_mask, 32'd0);
        check("t6_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        expect_ready("t6_in_flush_ready", 1'b0);
        step();
        check("t6_not_captured", {31'd0, bus.ex_valid}, 32'd0);
        #1;
        check("t6_run_ready", {31'd0, bus.id_ready}, 32'd1);
        bus.id_valid = 1'b0;
        step();
        step();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
